// File: rtl/life_support_pkg.sv
// Shared definitions for the life-support array: mode codes, zone state encoding, margins.
// Latency: n/a (package only).
// Backpressure: n/a.
package life_support_pkg;

  // Operating mode codes; 2'b11 is decoded as NORMAL by simply matching none of the others
  localparam logic [1:0] MODE_NORMAL  = 2'b00;
  localparam logic [1:0] MODE_DEFENSE = 2'b01;
  localparam logic [1:0] MODE_STEALTH = 2'b10;

  // Zone health, ordered so that a numerically larger code is a worse condition
  typedef enum logic [1:0] {
    ZS_NORMAL = 2'b00,
    ZS_WARN   = 2'b01,
    ZS_CRIT   = 2'b10,
    ZS_DEAD   = 2'b11
  } zone_state_t;

  // Temperature warning band sits this far below the critical limit
  localparam int TEMP_WARN_MARGIN = 10;

  // One recovery step toward NORMAL; DEAD never recovers
  function automatic zone_state_t zs_one_better(input zone_state_t s);
    case (s)
      ZS_CRIT: return ZS_WARN;
      ZS_WARN: return ZS_NORMAL;
      ZS_DEAD: return ZS_DEAD;
      default: return ZS_NORMAL;
    endcase
  endfunction

endpackage

// File: rtl/ls_zone.sv
// One habitable zone: O2 level, temperature and health state machine.
// Latency: levels update one cycle after the causing edge; state follows levels one cycle later.
// Backpressure: none; load strobes and ticks are accepted every cycle.
module ls_zone
  import life_support_pkg::*;
#(
  parameter int W          = 16,
  parameter int O2_WARN    = 100,
  parameter int TEMP_LIMIT = 100
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic [1:0]    mode,
  input  logic          powered,
  input  logic          o2_ld,
  input  logic [W-1:0]  o2_ld_val,
  input  logic [W-1:0]  temp_init,
  output logic [W-1:0]  o2,
  output logic [W-1:0]  temp,
  output zone_state_t   state
);

  localparam logic [W-1:0] O2_WARN_L   = W'(O2_WARN);
  localparam logic [W-1:0] O2_CRIT_L   = W'(O2_WARN / 4);
  localparam logic [W-1:0] TEMP_CRIT_L = W'(TEMP_LIMIT);
  localparam logic [W-1:0] TEMP_WARN_L = (TEMP_LIMIT > TEMP_WARN_MARGIN) ?
                                         W'(TEMP_LIMIT - TEMP_WARN_MARGIN) : '0;

  logic [W-1:0] o2_q, o2_d;
  logic [W-1:0] temp_q, temp_d;
  zone_state_t  state_q, state_d;
  zone_state_t  cls;

  // O2: a resupply load beats the decay tick
  always_comb begin
    o2_d = o2_q;
    if (o2_ld)                    o2_d = o2_ld_val;
    else if (tick && o2_q != '0)  o2_d = o2_q - 1'b1;
  end

  // Temperature: heats when unpowered or stealthed, otherwise drifts one step toward ambient
  always_comb begin
    temp_d = temp_q;
    if (tick) begin
      if (!powered || mode == MODE_STEALTH) begin
        if (temp_q != '1) temp_d = temp_q + 1'b1;
      end else if (temp_q > temp_init) begin
        temp_d = temp_q - 1'b1;
      end else if (temp_q < temp_init) begin
        temp_d = temp_q + 1'b1;
      end
    end
  end

  // Instantaneous classification of the registered levels
  always_comb begin
    cls = ZS_NORMAL;
    if (o2_q == '0)
      cls = ZS_DEAD;
    else if (o2_q < O2_CRIT_L || temp_q >= TEMP_CRIT_L)
      cls = ZS_CRIT;
    else if (o2_q < O2_WARN_L || temp_q >= TEMP_WARN_L)
      cls = ZS_WARN;
  end

  // Next state: jump straight to a worse class, recover one level per cycle, DEAD is absorbing
  always_comb begin
    state_d = state_q;
    if (state_q != ZS_DEAD) begin
      if (cls > state_q)      state_d = cls;
      else if (cls < state_q) state_d = zs_one_better(state_q);
    end
  end

  // Level and state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      o2_q    <= o2_ld_val;
      temp_q  <= temp_init;
      state_q <= ZS_NORMAL;
    end else begin
      o2_q    <= o2_d;
      temp_q  <= temp_d;
      state_q <= state_d;
    end
  end

  // Outputs are the registered values
  always_comb begin
    o2    = o2_q;
    temp  = temp_q;
    state = state_q;
  end

endmodule

// File: rtl/life_support_array.sv
// Ship life-support array: power, shield, decay ticker and N_ZONES zone monitors; LS_ATTACK_COUNT_EN adds an attack counter.
// Latency: every level registered, visible one cycle after the causing edge; fatal one cycle after its cause.
// Backpressure: none; all strobes are accepted every cycle.
module life_support_array
  import life_support_pkg::*;
#(
  parameter int N_ZONES    = 4,
  parameter int W          = 16,
  parameter int TICK_DIV   = 4,
  parameter int O2_WARN    = 100,
  parameter int TEMP_LIMIT = 100,
  parameter int SHIELD_MAX = 200,
  parameter int ATK_DMG    = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             mode,
  input  logic                   chrg,
  input  logic [W-1:0]           pwr_in,
  input  logic [N_ZONES-1:0]     o2sup,
  input  logic [N_ZONES*W-1:0]   o2_in,
  input  logic                   atk,
  input  logic [W-1:0]           shield_init,
  input  logic [W-1:0]           temp_init,
  output logic [W-1:0]           shield,
  output logic [W-1:0]           power,
  output logic [N_ZONES*W-1:0]   zone_o2,
  output logic [N_ZONES*W-1:0]   zone_temp,
  output logic [2*N_ZONES-1:0]   zone_state,
  output logic                   fatal,
  output logic [W-1:0]           atk_count
);

  localparam int            TW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [W-1:0]  ATK_L      = W'(ATK_DMG);
  localparam logic [W-1:0]  SHIELD_TOP = W'(SHIELD_MAX);

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [W-1:0]  power_q, power_d;
  logic [W-1:0]  shield_q, shield_d;
  logic          fatal_q, fatal_d;
  logic          tick;
  logic          powered;
  logic          any_dead;
  zone_state_t   zs [N_ZONES];

  assign tick    = (tick_cnt_q == TICK_LAST);
  assign powered = (power_q != '0);

  // Decay ticker wraps after TICK_DIV clocks
  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  // Power: a charge load beats the decay tick
  always_comb begin
    power_d = power_q;
    if (chrg)                        power_d = pwr_in;
    else if (tick && power_q != '0)  power_d = power_q - 1'b1;
  end

  // Shield: attack damage dominates; regeneration only on a powered DEFENSE tick below the ceiling
  always_comb begin
    shield_d = shield_q;
    if (atk)
      shield_d = (shield_q > ATK_L) ? shield_q - ATK_L : '0;
    else if (tick && mode == MODE_DEFENSE && powered && shield_q < SHIELD_TOP)
      shield_d = shield_q + 1'b1;
  end

  // Any zone currently in DEAD
  always_comb begin
    any_dead = 1'b0;
    for (int i = 0; i < N_ZONES; i++)
      if (zs[i] == ZS_DEAD) any_dead = 1'b1;
  end

  // Ship loss latches until reset
  always_comb begin
    fatal_d = fatal_q | any_dead | (shield_q == '0);
  end

  // Core registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
      power_q    <= pwr_in;
      shield_q   <= shield_init;
      fatal_q    <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      power_q    <= power_d;
      shield_q   <= shield_d;
      fatal_q    <= fatal_d;
    end
  end

  for (genvar gi = 0; gi < N_ZONES; gi++) begin : g_zone
    ls_zone #(
      .W          (W),
      .O2_WARN    (O2_WARN),
      .TEMP_LIMIT (TEMP_LIMIT)
    ) u_zone (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .mode      (mode),
      .powered   (powered),
      .o2_ld     (o2sup[gi]),
      .o2_ld_val (o2_in[gi*W +: W]),
      .temp_init (temp_init),
      .o2        (zone_o2[gi*W +: W]),
      .temp      (zone_temp[gi*W +: W]),
      .state     (zs[gi])
    );
    assign zone_state[2*gi +: 2] = zs[gi];
  end

  assign shield = shield_q;
  assign power  = power_q;
  assign fatal  = fatal_q;

`ifdef LS_ATTACK_COUNT_EN
  logic [W-1:0] atk_count_q, atk_count_d;

  // Count attack cycles, saturating at all-ones
  always_comb begin
    atk_count_d = atk_count_q;
    if (atk && atk_count_q != '1) atk_count_d = atk_count_q + 1'b1;
  end

  // Attack counter register
  always_ff @(posedge clk) begin
    if (rst) atk_count_q <= '0;
    else     atk_count_q <= atk_count_d;
  end

  assign atk_count = atk_count_q;
`else
  assign atk_count = '0;
`endif

endmodule
